// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared encodings, line table and board helpers for the tic-tac-toe controller
package ttt_pkg;

    localparam int BOARD_W = 18;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] PX    = 2'd1;
    localparam logic [1:0] PO    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_WIN   = 3'd3,
        S_DRAW  = 3'd4
    } state_t;

    // LINE_TABLE[k][j] is the j-th cell of line k; line 0 sits in the low bits
    localparam logic [7:0][2:0][3:0] LINE_TABLE = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

    // Positions 9..15 read back as EMPTY so callers never slice past the board
    function automatic logic [1:0] get_cell(input logic [BOARD_W-1:0] b, input logic [3:0] pos);
        get_cell = EMPTY;
        for (int c = 0; c < 9; c++) begin
            if (pos == 4'(c)) begin
                get_cell = b[2*c +: 2];
            end
        end
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - flags when all three cells of the selected line hold the given player
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [2:0]         line_idx,
    input  logic [1:0]         player,
    output logic               match
);

    always_comb begin
        match = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (get_cell(board, LINE_TABLE[line_idx][j]) != player) begin
                match = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game FSM: move entry, sequential line checking, win/draw detection
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int FIRST_PLAYER = 1
) (
    input  logic               freq,
    input  logic               rst,
    input  logic               new_game,
    input  logic               key_valid,
    input  logic [3:0]         key_pos,
    output logic [BOARD_W-1:0] board,
    output logic [1:0]         turn,
    output logic [2:0]         game_state,
    output logic [1:0]         winner,
    output logic [3:0]         win_line,
    output logic [3:0]         moves,
    output logic               move_err
);

    localparam logic [1:0] FIRST = 2'(FIRST_PLAYER);

    state_t             state, state_n;
    logic [BOARD_W-1:0] board_n;
    logic [1:0]         turn_n, winner_n;
    logic [3:0]         win_line_n, moves_n;
    logic               move_err_n;
    logic [2:0]         line_idx, line_idx_n;
    logic               line_match;
    logic               key_ok;

    ttt_line_check u_line_check (
        .board    (board),
        .line_idx (line_idx),
        .player   (turn),
        .match    (line_match)
    );

    assign game_state = state;
    assign key_ok     = (key_pos <= 4'd8) && (get_cell(board, key_pos) == EMPTY);

    always_ff @(posedge freq or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            board    <= '0;
            turn     <= FIRST;
            winner   <= EMPTY;
            win_line <= 4'd0;
            moves    <= 4'd0;
            move_err <= 1'b0;
            line_idx <= 3'd0;
        end else begin
            state    <= state_n;
            board    <= board_n;
            turn     <= turn_n;
            winner   <= winner_n;
            win_line <= win_line_n;
            moves    <= moves_n;
            move_err <= move_err_n;
            line_idx <= line_idx_n;
        end
    end

    always_comb begin
        state_n    = state;
        board_n    = board;
        turn_n     = turn;
        winner_n   = winner;
        win_line_n = win_line;
        moves_n    = moves;
        move_err_n = 1'b0;
        line_idx_n = line_idx;

        // new_game overrides everything, including a coincident key
        if (new_game) begin
            state_n    = S_PLAY;
            board_n    = '0;
            turn_n     = FIRST;
            winner_n   = EMPTY;
            win_line_n = 4'd0;
            moves_n    = 4'd0;
            line_idx_n = 3'd0;
        end else begin
            case (state)
                S_PLAY: begin
                    if (key_valid) begin
                        if (key_ok) begin
                            for (int c = 0; c < 9; c++) begin
                                if (key_pos == 4'(c)) begin
                                    board_n[2*c +: 2] = turn;
                                end
                            end
                            moves_n    = moves + 4'd1;
                            line_idx_n = 3'd0;
                            state_n    = S_CHECK;
                        end else begin
                            move_err_n = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (line_match) begin
                        state_n    = S_WIN;
                        winner_n   = turn;
                        win_line_n = {1'b0, line_idx};
                    end else if (line_idx == 3'd7) begin
                        if (moves == 4'd9) begin
                            state_n = S_DRAW;
                        end else begin
                            turn_n  = (turn == PX) ? PO : PX;
                            state_n = S_PLAY;
                        end
                    end else begin
                        line_idx_n = line_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - directed table-driven bench for ttt_game_ctrl
module tb_ttt_game_ctrl;

    logic        freq = 1'b0;
    logic        rst;
    logic        new_game;
    logic        key_valid;
    logic [3:0]  key_pos;
    logic [17:0] board;
    logic [1:0]  turn;
    logic [2:0]  game_state;
    logic [1:0]  winner;
    logic [3:0]  win_line;
    logic [3:0]  moves;
    logic        move_err;

    int checks   = 0;
    int failures = 0;

    ttt_game_ctrl #(.FIRST_PLAYER(1)) dut (
        .freq       (freq),
        .rst        (rst),
        .new_game   (new_game),
        .key_valid  (key_valid),
        .key_pos    (key_pos),
        .board      (board),
        .turn       (turn),
        .game_state (game_state),
        .winner     (winner),
        .win_line   (win_line),
        .moves      (moves),
        .move_err   (move_err)
    );

    always #5 freq = ~freq;

    typedef struct {
        logic        ng;
        logic        kv;
        logic [3:0]  pos;
        int          gap;
        logic [17:0] e_board;
        logic [1:0]  e_turn;
        logic [2:0]  e_state;
        logic [1:0]  e_winner;
        logic [3:0]  e_wl;
        logic [3:0]  e_moves;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge freq);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [17:0] b, input logic [1:0] t,
                           input logic [2:0] s, input logic [1:0] w, input logic [3:0] wl,
                           input logic [3:0] m, input logic e);
        chk({tag, ".board"},    32'(board),      32'(b));
        chk({tag, ".turn"},     32'(turn),       32'(t));
        chk({tag, ".state"},    32'(game_state), 32'(s));
        chk({tag, ".winner"},   32'(winner),     32'(w));
        chk({tag, ".win_line"}, 32'(win_line),   32'(wl));
        chk({tag, ".moves"},    32'(moves),      32'(m));
        chk({tag, ".move_err"}, 32'(move_err),   32'(e));
    endtask

    function automatic vec_t mk(input logic ng, input logic kv, input logic [3:0] pos, input int gap,
                                input logic [17:0] b, input logic [1:0] t, input logic [2:0] s,
                                input logic [1:0] w, input logic [3:0] wl, input logic [3:0] m,
                                input logic e);
        vec_t v;
        v.ng = ng; v.kv = kv; v.pos = pos; v.gap = gap;
        v.e_board = b; v.e_turn = t; v.e_state = s; v.e_winner = w;
        v.e_wl = wl; v.e_moves = m; v.e_err = e;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row win on line 0
        vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 18'h00001, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 7, 18'h00001, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 3, 8, 18'h00081, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 1, 8, 18'h00085, 2, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 4, 8, 18'h00285, 1, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 2, 0, 18'h00295, 1, 2, 0, 0, 5, 0));
        vecs.push_back(mk(0, 0, 0, 0, 18'h00295, 1, 3, 1, 0, 5, 0));
        vecs.push_back(mk(0, 1, 5, 3, 18'h00295, 1, 3, 1, 0, 5, 0));
        // Occupied cell, invalid keys, new_game beating a coincident key
        vecs.push_back(mk(1, 1, 0, 0, 18'h00000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 4, 8, 18'h00100, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 4, 0, 18'h00100, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 18'h00100, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 9, 0, 18'h00100, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 15, 0, 18'h00100, 2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 18'h00100, 2, 1, 0, 0, 1, 0));
        // Draw
        vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8, 18'h00001, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 8, 18'h00009, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 2, 8, 18'h00019, 2, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 4, 8, 18'h00219, 1, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 3, 8, 18'h00259, 2, 1, 0, 0, 5, 0));
        vecs.push_back(mk(0, 1, 5, 8, 18'h00A59, 1, 1, 0, 0, 6, 0));
        vecs.push_back(mk(0, 1, 7, 8, 18'h04A59, 2, 1, 0, 0, 7, 0));
        vecs.push_back(mk(0, 1, 6, 8, 18'h06A59, 1, 1, 0, 0, 8, 0));
        vecs.push_back(mk(0, 1, 8, 7, 18'h16A59, 1, 2, 0, 0, 9, 0));
        vecs.push_back(mk(0, 0, 0, 0, 18'h16A59, 1, 4, 0, 0, 9, 0));
        vecs.push_back(mk(0, 1, 0, 2, 18'h16A59, 1, 4, 0, 0, 9, 0));
        // Win on the ninth move (line 6) must not be a draw
        vecs.push_back(mk(1, 0, 0, 0, 18'h00000, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8, 18'h00001, 2, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 8, 18'h00009, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, 4, 8, 18'h00109, 2, 1, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, 2, 8, 18'h00129, 1, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 5, 8, 18'h00529, 2, 1, 0, 0, 5, 0));
        vecs.push_back(mk(0, 1, 3, 8, 18'h005A9, 1, 1, 0, 0, 6, 0));
        vecs.push_back(mk(0, 1, 7, 8, 18'h045A9, 2, 1, 0, 0, 7, 0));
        vecs.push_back(mk(0, 1, 6, 8, 18'h065A9, 1, 1, 0, 0, 8, 0));
        vecs.push_back(mk(0, 1, 8, 6, 18'h165A9, 1, 2, 0, 0, 9, 0));
        vecs.push_back(mk(0, 0, 0, 0, 18'h165A9, 1, 3, 1, 6, 9, 0));
        vecs.push_back(mk(0, 0, 0, 4, 18'h165A9, 1, 3, 1, 6, 9, 0));

        rst = 1'b1; new_game = 1'b0; key_valid = 1'b0; key_pos = 4'd0;
        #1;
        chk_all("reset", 18'h0, 1, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // IDLE ignores keys
        key_valid = 1'b1; key_pos = 4'd0;
        tick();
        key_valid = 1'b0;
        chk_all("idle_key", 18'h0, 1, 0, 0, 0, 0, 0);

        // Abort: key during CHECK ignored, new_game during CHECK restarts
        new_game = 1'b1; tick(); new_game = 1'b0;
        key_valid = 1'b1; key_pos = 4'd4; tick();
        key_pos = 4'd0; tick();
        key_valid = 1'b0;
        chk_all("check_key", 18'h00100, 1, 2, 0, 0, 1, 0);
        tick();
        chk("check_key_err2", 32'(move_err), 32'd0);
        new_game = 1'b1; tick(); new_game = 1'b0;
        chk_all("abort", 18'h0, 1, 1, 0, 0, 0, 0);
        repeat (9) tick();
        chk_all("abort_settled", 18'h0, 1, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            new_game  = vecs[i].ng;
            key_valid = vecs[i].kv;
            key_pos   = vecs[i].pos;
            tick();
            new_game = 1'b0; key_valid = 1'b0; key_pos = 4'd0;
            repeat (vecs[i].gap) tick();
            chk_all(tag, vecs[i].e_board, vecs[i].e_turn, vecs[i].e_state,
                    vecs[i].e_winner, vecs[i].e_wl, vecs[i].e_moves, vecs[i].e_err);
        end

        // Asynchronous reset between edges while in WIN
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 18'h0, 1, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        chk_all("post_rst", 18'h0, 1, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter: FIRST_PLAYER, default 1, cell code of the player who moves first after new_game (1 or 2).
REQ-002 freq  in  1  system clock (25 MHz); all state changes on its rising edge.
REQ-003 rst  in  1  reset; asynchronous and active-high.
REQ-004 new_game  in  1  one-cycle pulse; clears the board and starts a game.
REQ-005 key_valid  in  1  one-cycle pulse; key_pos carries a move.
REQ-006 key_pos  in  4  target cell 0..8; values 9..15 are invalid.
REQ-007 board  out  18  cell k in board[2k+1:2k]; codes 0 = empty, 1 = player X, 2 = player O; code 3 is never produced.
REQ-008 turn  out  2  cell code of the player to move (1 or 2).
REQ-009 game_state  out  3  0 IDLE, 1 PLAY, 2 CHECK, 3 WIN, 4 DRAW.
REQ-010 winner  out  2  code of the winning player; 0 unless in WIN.
REQ-011 win_line  out  4  index 0..7 of the winning line; 0 unless in WIN.
REQ-012 moves  out  4  number of occupied cells, 0..9.
REQ-013 move_err  out  1  one-cycle pulse on a rejected move.

Function
REQ-014 Line table, fixed:
- 0 = {0,1,2}, 1 = {3,4,5}, 2 = {6,7,8}
- 3 = {0,3,6}, 4 = {1,4,7}, 5 = {2,5,8}
- 6 = {0,4,8}, 7 = {2,4,6}
REQ-015 IDLE: key_valid is ignored. new_game clears board and moves, sets turn = FIRST_PLAYER, and enters PLAY.
REQ-016 PLAY, key_valid, key_pos <= 8 and the cell is empty, at edge N:
- the cell is written with turn and moves increments;
- the FSM enters CHECK with line index 0;
- all of this is visible after edge N.
REQ-017 PLAY, key_valid with key_pos > 8 or an occupied cell: move_err = 1 for exactly the next cycle; board, turn, moves and state are unchanged.
REQ-018 CHECK evaluates one line per cycle on the registered board, index 0..7; line k is evaluated at edge N+1+k.
REQ-019 CHECK, line k has all three cells equal to turn: go to WIN with winner = turn and win_line = k (first match wins).
REQ-020 CHECK, index 7 with no match: go to DRAW if moves == 9, else toggle turn (1<->2) and return to PLAY. Worst-case latency is 8 cycles.
REQ-021 A win found on the 9th move yields WIN, not DRAW.
REQ-022 key_valid during CHECK, WIN or DRAW is ignored, with no move_err.
REQ-023 WIN and DRAW hold board, winner and win_line until new_game.
REQ-024 new_game in any non-IDLE state:
- clears board, moves, winner and win_line;
- sets turn = FIRST_PLAYER and enters PLAY;
- aborts any CHECK in progress.
REQ-025 new_game and key_valid in the same cycle: new_game wins and the key is discarded.
REQ-026 move_err is never asserted in the same cycle as a board write.

Reset
REQ-027 On rst, asynchronously:
- board = 0, turn = FIRST_PLAYER, game_state = IDLE;
- winner = 0, win_line = 0, moves = 0, move_err = 0, line index = 0.
REQ-028 rst asserted mid-CHECK or mid-game discards all progress; no partial write survives.

Structure
REQ-029 Shared package ttt_pkg holds:
- the state encoding;
- the cell codes EMPTY/PX/PO;
- the 8x3 line table constant;
- the board width (18).
REQ-030 One combinational sub-module, ttt_line_check (inputs board, line index, player; output match), is instantiated once.
REQ-031 board shall connect directly to the dot-matrix display board input, with no re-encoding.

Verification
REQ-032 Row win: rst, new_game, then X0, O3, X1, O4, X2 -> board = 18'h00295, WIN at edge N+1 after the last key, winner = 1, win_line = 0, moves = 5.
REQ-033 Occupied cell: X4, then O4 -> move_err high for 1 cycle, board = 18'h00100, turn = 2, game_state = PLAY.
REQ-034 Invalid key: key_pos = 9 in PLAY -> move_err pulse, moves unchanged.
REQ-035 Draw: X0, O1, X2, O4, X3, O5, X7, O6, X8 -> DRAW 8 cycles after the last key, winner = 0, moves = 9.
REQ-036 Abort: key_valid during CHECK -> ignored with no move_err; new_game during CHECK -> board = 0, PLAY, turn = FIRST_PLAYER.
REQ-037 Async reset: rst pulsed between clock edges while in WIN -> outputs reach reset values immediately, without waiting for a clock edge.
